mult_hilo_unit: RTL and testbench

MULT_HILO_UNIT -- requirements
Module: mult_hilo_unit

---
 rtl/mult_pkg.sv | 15 +
 rtl/mult_hilo_unit_multu.sv | 10 +
 rtl/mult_hilo_unit.sv | 100 ++++++++++
 tb/tb_mult_hilo_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the HI/LO multiply unit.
package mult_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PROD_W  = 2 * DATA_W;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

endpackage

// File: rtl/mult_hilo_unit_multu.sv
// Unsigned 32x32 -> 64 combinational multiplier.
module Multu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] z
);

    assign z = {32'd0, a} * {32'd0, b};

endmodule

// File: rtl/mult_hilo_unit.sv
// MIPS-style HI/LO multiply unit: sign-magnitude wrapper around an unsigned
// multiplier, given LAT cycles to settle, plus MTHI/MTLO moves while idle.
module mult_hilo_unit
    import mult_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_signed,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                mthi,
    input  logic                mtlo,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo,
    output logic                busy,
    output logic                done
);

    // Out-of-range LAT is clamped so the counter compare stays meaningful.
    localparam int unsigned LAT_EFF = (LAT < LAT_MIN) ? LAT_MIN :
                                      (LAT > LAT_MAX) ? LAT_MAX : LAT;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAT_EFF - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  hi_q, lo_q;
    logic [DATA_W-1:0]  mag_a_q, mag_b_q;
    logic               neg_q, signed_q;
    logic               busy_q, done_q;

    logic [DATA_W-1:0]  mag_a_c, mag_b_c;
    logic               neg_c;
    logic [PROD_W-1:0]  prod_c, result_c;

    // 0x80000000 negates to itself, which is the correct magnitude 2^31.
    assign mag_a_c  = (is_signed & a[DATA_W-1]) ? -a : a;
    assign mag_b_c  = (is_signed & b[DATA_W-1]) ? -b : b;
    assign neg_c    = is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);

    Multu u_multu (
        .a (mag_a_q),
        .b (mag_b_q),
        .z (prod_c)
    );

    assign result_c = (signed_q & neg_q) ? -prod_c : prod_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            neg_q    <= 1'b0;
            signed_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mthi) hi_q <= wdata;
                    if (mtlo) lo_q <= wdata;
                    if (start) begin
                        mag_a_q  <= mag_a_c;
                        mag_b_q  <= mag_b_c;
                        neg_q    <= neg_c;
                        signed_q <= is_signed;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Product has had LAT cycles on stable operands by this edge.
                    if (cnt_q == LAST_CNT) begin
                        {hi_q, lo_q} <= result_c;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Randomized scoreboard bench for mult_hilo_unit against an arithmetic reference.
module tb_mult_hilo_unit;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst, start, is_signed, mthi, mtlo;
    logic [31:0] a, b, wdata, hi, lo;
    logic        busy, done;

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;

    logic [63:0] sb_q[$];
    logic [31:0] hi_m, lo_m;

    always #5 clk = ~clk;

    mult_hilo_unit #(.LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                             input logic s);
        longint sx, sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding product.
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            chk("done_busy_exclusive", 64'(busy), 64'd0);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: hi=0x%0h lo=0x%0h at %0t", hi, lo, $time);
            end else begin
                chk("product", {hi, lo}, sb_q.pop_front());
            end
        end
    end

    // Returns at the negedge after edge N (first busy cycle).
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input logic mh, input logic ml, input logic [31:0] wd);
        logic [63:0] p;
        logic [31:0] mv_hi, mv_lo;
        @(negedge clk);
        a = x; b = y; is_signed = s; start = 1'b1;
        mthi = mh; mtlo = ml; wdata = wd;
        mv_hi = mh ? wd : hi_m;
        mv_lo = ml ? wd : lo_m;
        p = ref_prod(x, y, s);
        sb_q.push_back(p);
        {hi_m, lo_m} = p;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        if (mh | ml) chk("move_with_start", {hi, lo}, {mv_hi, mv_lo});
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic finish_op(input int seen, input int d0);
        int n;
        n = seen;
        while (busy && n < 64) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("busy_cycles", 64'(n), 64'(LAT));
        chk("done_pulse", 64'(done), 64'd1);
        chk("hilo_after_op", {hi, lo}, {hi_m, lo_m});
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("done_count", 64'(n_done - d0), 64'd1);
    endtask

    task automatic run_mult(input logic [31:0] x, input logic [31:0] y, input logic s);
        int d0;
        d0 = n_done;
        issue(x, y, s, 1'b0, 1'b0, 32'd0);
        finish_op(1, d0);
    endtask

    task automatic do_move(input logic mh, input logic ml, input logic [31:0] wd);
        @(negedge clk);
        mthi = mh; mtlo = ml; wdata = wd;
        if (mh) hi_m = wd;
        if (ml) lo_m = wd;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("move", {hi, lo}, {hi_m, lo_m});
        chk("move_busy", 64'(busy), 64'd0);
        chk("move_done", 64'(done), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners[5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b0; start = 1'b0; is_signed = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        a = '0; b = '0; wdata = '0;
        hi_m = '0; lo_m = '0;
        repeat (3) @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst = 1'b1;

        // Unsigned max * max
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        // Signed -1 * 1 and min * min
        run_mult(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        chk("mult_neg1", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        run_mult(32'h8000_0000, 32'h8000_0000, 1'b1);
        chk("mult_min_min", {hi, lo}, 64'h4000_0000_0000_0000);

        // Start and mthi during CALC are ignored
        d0 = n_done;
        issue(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0);
        a = 32'd7; b = 32'd7; start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        finish_op(2, d0);
        chk("ignore_in_calc", {hi, lo}, 64'd15);

        // Reset during CALC aborts the multiply
        @(negedge clk);
        a = 32'd3; b = 32'd5; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        hi_m = '0; lo_m = '0;
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        d0 = n_done;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        chk("abort_hilo_late", {hi, lo}, 64'd0);

        // Dual move writes both registers
        do_move(1'b1, 1'b1, 32'h1234_5678);
        chk("move_both", {hi, lo}, 64'h1234_5678_1234_5678);

        // Move coincident with start, product overwrites later
        d0 = n_done;
        issue(32'd2, 32'd4, 1'b0, 1'b0, 1'b1, 32'hAAAA_5555);
        finish_op(1, d0);
        chk("start_with_move", {hi, lo}, 64'd8);

        // Randomized mix of multiplies and moves
        for (int i = 0; i < 40; i++) begin
            logic [31:0] x, y, wd;
            logic s, mh, ml;
            x  = pick_operand();
            y  = pick_operand();
            s  = 1'($urandom_range(0, 1));
            wd = $urandom;
            mh = 1'($urandom_range(0, 1));
            ml = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: do_move(mh, ml, wd);
                1: begin
                    d0 = n_done;
                    issue(x, y, s, mh, ml, wd);
                    finish_op(1, d0);
                end
                default: run_mult(x, y, s);
            endcase
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
